// File: rtl/param_acc_cpu_pkg.sv
// Shared constants for the parametrised accumulator core: opcode field width,
// opcode values and the FSM state encoding.
package param_acc_cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUBI = 4'd3;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'd4;
    localparam logic [OPC_W-1:0] OP_LDR  = 4'd5;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd6;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd7;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd8;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd9;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'd10;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'd11;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'd12;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'd13;
    localparam logic [OPC_W-1:0] OP_HALT = 4'd14;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_MUL    = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/param_acc_cpu_mul.sv
// Iterative shift-add multiplier returning the low DATA_W bits of a*b.
// A start pulse loads the operands; o_done is high on the DATA_W-th cycle
// after start, and o_product is valid in that same cycle.
module seq_multiplier #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);
    import param_acc_cpu_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_p;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;
    logic [DATA_W-1:0] w_p_next;

    // Partial product after the current step; the final step's value is the result.
    always_comb begin
        w_p_next = r_p;
        if (r_b[0]) begin
            w_p_next = r_p + r_a;
        end
    end

    assign o_done    = r_run && (r_cnt == '0);
    assign o_product = w_p_next;

    // One multiplier bit per cycle; the down-counter's terminal count ends the run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_p   <= '0;
            r_cnt <= CNT_W'(DATA_W - 1);
            r_run <= 1'b1;
        end else if (r_run) begin
            r_p <= w_p_next;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/param_acc_cpu.sv
// Parametrised accumulator core with a valid/ready instruction stream,
// register file, Z/C flags, iterative multiplier and a sticky HALT.
//
// state   | meaning
// IDLE    | ready for an instruction
// EXEC    | executing the captured instruction (one cycle)
// MUL     | waiting DATA_W cycles for the multiplier
// HALTED  | stopped until reset
module param_acc_cpu #(
    parameter int DATA_W = 16,
    parameter int ARG_W  = 8,
    parameter int NREGS  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ARG_W+3:0]    in_instr,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   outvalue,
    output logic                out_valid,
    output logic                busy,
    output logic                halted,
    output logic                flag_z,
    output logic                flag_c
);
    import param_acc_cpu_pkg::*;

    localparam int IDX_W = $clog2(NREGS);

    logic [1:0]             r_state;
    logic                   r_live;
    logic [ARG_W+3:0]       r_ir;
    logic [DATA_W-1:0]      r_acc;
    logic [DATA_W-1:0]      r_regs [NREGS];
    logic [DATA_W-1:0]      r_outvalue;
    logic                   r_out_valid;
    logic                   r_z;
    logic                   r_c;

    logic [OPC_W-1:0]       w_op;
    logic [ARG_W-1:0]       w_arg;
    logic [IDX_W-1:0]       w_idx;
    logic [DATA_W-1:0]      w_imm;
    logic [DATA_W-1:0]      w_reg;
    logic [DATA_W-1:0]      w_acc_next;
    logic                   w_c_next;
    logic                   w_wr_acc;
    logic                   w_wr_c;
    logic [DATA_W:0]        w_ext;
    logic                   w_mul_start;
    logic                   w_mul_done;
    logic [DATA_W-1:0]      w_mul_product;

    assign w_op  = r_ir[ARG_W +: OPC_W];
    assign w_arg = r_ir[ARG_W-1:0];
    assign w_idx = w_arg[IDX_W-1:0];
    assign w_imm = DATA_W'(w_arg);
    assign w_reg = r_regs[w_idx];

    assign w_mul_start = (r_state == ST_EXEC) && (w_op == OP_MUL);

    // in_ready waits one clock after reset release so nothing is accepted during reset.
    assign in_ready  = r_live && (r_state == ST_IDLE);
    assign busy      = (r_state == ST_EXEC) || (r_state == ST_MUL);
    assign halted    = (r_state == ST_HALTED);
    assign outvalue  = r_outvalue;
    assign out_valid = r_out_valid;
    assign flag_z    = r_z;
    assign flag_c    = r_c;

    seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clock     (clock),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_a       (r_acc),
        .i_b       (w_reg),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // Single-cycle ALU: next accumulator and carry for the captured opcode.
    always_comb begin
        w_acc_next = r_acc;
        w_c_next   = r_c;
        w_wr_acc   = 1'b0;
        w_wr_c     = 1'b0;
        w_ext      = '0;
        case (w_op)
            OP_LDI: begin
                w_acc_next = w_imm;
                w_wr_acc   = 1'b1;
            end
            OP_ADDI, OP_ADD: begin
                w_ext      = {1'b0, r_acc} + {1'b0, (w_op == OP_ADD) ? w_reg : w_imm};
                w_acc_next = w_ext[DATA_W-1:0];
                w_c_next   = w_ext[DATA_W];
                w_wr_acc   = 1'b1;
                w_wr_c     = 1'b1;
            end
            OP_SUBI, OP_SUB: begin
                w_ext      = {1'b0, r_acc} - {1'b0, (w_op == OP_SUB) ? w_reg : w_imm};
                w_acc_next = w_ext[DATA_W-1:0];
                w_c_next   = w_ext[DATA_W];
                w_wr_acc   = 1'b1;
                w_wr_c     = 1'b1;
            end
            OP_LDR: begin
                w_acc_next = w_reg;
                w_wr_acc   = 1'b1;
            end
            OP_AND: begin
                w_acc_next = r_acc & w_reg;
                w_wr_acc   = 1'b1;
            end
            OP_XOR: begin
                w_acc_next = r_acc ^ w_reg;
                w_wr_acc   = 1'b1;
            end
            OP_SHL: begin
                w_acc_next = {r_acc[DATA_W-2:0], 1'b0};
                w_c_next   = r_acc[DATA_W-1];
                w_wr_acc   = 1'b1;
                w_wr_c     = 1'b1;
            end
            OP_SHR: begin
                w_acc_next = {1'b0, r_acc[DATA_W-1:1]};
                w_c_next   = r_acc[0];
                w_wr_acc   = 1'b1;
                w_wr_c     = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer, architectural state and output register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_outvalue  <= '0;
            r_out_valid <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_live      <= 1'b1;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_ir    <= in_instr;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_wr_acc) begin
                        r_acc <= w_acc_next;
                        r_z   <= (w_acc_next == '0);
                    end
                    if (w_wr_c) begin
                        r_c <= w_c_next;
                    end
                    if (w_op == OP_MOV) begin
                        r_regs[w_idx] <= r_acc;
                    end
                    if (w_op == OP_OUT) begin
                        r_outvalue  <= r_acc;
                        r_out_valid <= 1'b1;
                    end
                    if (w_op == OP_MUL) begin
                        r_state <= ST_MUL;
                    end else if (w_op == OP_HALT) begin
                        r_state <= ST_HALTED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_acc   <= w_mul_product;
                        r_z     <= (w_mul_product == '0);
                        r_c     <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_HALTED;
            endcase
        end
    end

endmodule
